hci_ecc_err_tracker: RTL and testbench
======================================

Name: hci_ecc_err_tracker

Overview:
- Sits beside the ECC-protected TCDM initiator port, between the ECC encoder/decoder wrapper and the TCDM interconnect.
- Consumes the per-response error flags produced by the ECC stage: data/meta, single/multi.
- Correlates each flagged response with the address of its originating request, using an internal outstanding-address FIFO.
- Keeps saturating error counters, captures the first failing address, and raises a one-cycle interrupt on uncorrectable errors.

Parameters:
AW, 32, TCDM address width
CNT_W, 16, width of each error counter
ADDR_FIFO_DEPTH, 8, outstanding-request capacity; must be >= max number of granted-but-unanswered TCDM requests
Note: power of two, >= 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of all state
enable_i  in  1  counting/capture enable
tcdm_req_i  in  1  snooped TCDM request valid
tcdm_gnt_i  in  1  snooped TCDM grant
tcdm_add_i  in  AW  snooped TCDM request address
tcdm_r_valid_i  in  1  snooped response valid
tcdm_r_ready_i  in  1  snooped response ready
r_data_single_err_i  in  1  correctable data error on current response
r_data_multi_err_i  in  1  uncorrectable data error on current response
r_meta_single_err_i  in  1  correctable meta error on current response
r_meta_multi_err_i  in  1  uncorrectable meta error on current response
single_cnt_o  out  CNT_W  saturating count of responses with any single error
multi_cnt_o  out  CNT_W  saturating count of responses with any multi error
first_err_valid_o  out  1  a first-error record is held
first_err_addr_o  out  AW  address of first erroneous response
first_err_type_o  out  4  {meta_multi, meta_single, data_multi, data_single} of that response
irq_o  out  1  one-cycle pulse on each counted multi error
overflow_o  out  1  sticky: push attempted while FIFO full
underflow_o  out  1  sticky: response seen with FIFO empty

Behaviour:
- Reset (rst_ni=0, async): all outputs 0; FIFO empty; read and write pointers 0.
- clear_i=1 has the same effect as reset, applied synchronously. clear_i takes priority over every other event in that cycle.
- Push: on tcdm_req_i & tcdm_gnt_i, write tcdm_add_i at wptr and increment wptr.
- Pop: on tcdm_r_valid_i & tcdm_r_ready_i, read at rptr and increment rptr.
- The FIFO tracks push/pop regardless of enable_i, so correlation survives enable toggling.
- Simultaneous push and pop are always legal, including when full or empty:
  - Full: the pop frees the slot written by the same-cycle push; the push is accepted.
  - Empty: see the empty-pop rule below.
- Wrap-around: pointers are log2(DEPTH)+1 bits wide; full/empty are derived from the MSB and index comparison.
- Push when full with no pop: push dropped; overflow_o set and held until clear/reset.
- Pop when empty:
  - underflow_o set (sticky).
  - If a push occurs in the same cycle, the popped address is the same-cycle tcdm_add_i (bypass). Otherwise the popped address is 0.
  - Pointers do not move on an empty pop unless a same-cycle push also occurs.
- Error evaluation: only on a pop cycle with enable_i=1. single = data_single|meta_single; multi = data_multi|meta_multi.
- Counters:
  - single_cnt_o += single and multi_cnt_o += multi, both registered one cycle after the pop.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - A response with both single and multi set increments both counters.
- irq_o: 1 in the cycle after a pop with multi=1 and enable_i=1. Back-to-back multi errors give a high level on consecutive cycles.
- First-error capture:
  - When first_err_valid_o=0 and (single|multi), latch the popped address and the 4 flags; set first_err_valid_o the next cycle.
  - Further errors do not overwrite the record until clear/reset.
- Latency: 1 cycle from the response handshake to every output update.
- Error flags are ignored when no pop occurs.
- Reset mid-operation: all in-flight addresses are discarded. No recovery of outstanding correlation.

Decomposition:
- hci_package gains:
  - typedef hci_ecc_err_t, a packed struct {meta_multi, meta_single, data_multi, data_single};
  - constant HCI_ECC_ERR_W = 4.
- Sub-module hci_ecc_addr_fifo holds the pointer logic and the full/empty/bypass handling:
  - parameters AW, DEPTH;
  - ports push/pop/full/empty/data.
- The top level holds the counters, capture, irq and sticky flags.

Test Plan:
- Reset, then 3 requests granted at 0x100, 0x104, 0x108, with responses 2 cycles later and data_single on the 2nd only -> single_cnt_o=1, multi_cnt_o=0, first_err_addr_o=0x104, first_err_type_o=4'b0001, irq_o never high.
- Multi-error sequence: data_multi on the 1st response, meta_multi on the 3rd -> multi_cnt_o=2, irq_o high exactly 2 isolated cycles, first_err_addr_o = 1st address, type 4'b0010.
- Saturation: CNT_W=4, 20 consecutive single-error responses -> single_cnt_o stops at 15; clear_i pulse -> all outputs 0 next cycle.
- Full and wrap:
  - DEPTH=8: 8 grants with no responses, then a 9th grant -> overflow_o=1.
  - Then 20 interleaved push/pop pairs across pointer wrap, with an error injected on the 13th pair -> captured address equals the 13th pushed address.
- Empty pop:
  - Response with the FIFO empty -> underflow_o=1, first_err_addr_o=0 if that response had an error.
  - Same-cycle push at 0x200 plus empty pop with error -> first_err_addr_o=0x200.
- Enable gating: enable_i=0 during 5 error responses, then 1 for 1 error -> single_cnt_o=1, and the captured address is the 6th request's, proving the FIFO kept tracking while disabled.

Source files
------------

// File: rtl/hci_ecc_err_tracker_pkg.sv
// Shared types for the TCDM ECC error tracker: the per-response error flag record
// and helpers that fold it into single/multi error classes.
package hci_ecc_err_tracker_pkg;

    localparam int unsigned HCI_ECC_ERR_W = 4;

    typedef struct packed {
        logic meta_multi;
        logic meta_single;
        logic data_multi;
        logic data_single;
    } hci_ecc_err_t;

    function automatic logic ecc_is_single(input hci_ecc_err_t err);
        return err.data_single | err.meta_single;
    endfunction

    function automatic logic ecc_is_multi(input hci_ecc_err_t err);
        return err.data_multi | err.meta_multi;
    endfunction

endpackage

// File: rtl/hci_ecc_addr_fifo.sv
// Outstanding-request address FIFO: pushes granted request addresses, pops one per
// response handshake, and bypasses the same-cycle push address when popped empty.
module hci_ecc_addr_fifo #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [AW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [AW-1:0] pop_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [AW-1:0] mem [DEPTH];
    logic          push_acc;
    logic          pop_acc;

    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);

    // A pop frees the slot a full-FIFO push reuses; an empty pop only consumes the bypassed push.
    assign push_acc = push_i & (~full_o | pop_i);
    assign pop_acc  = pop_i & (~empty_o | push_i);

    assign pop_data_o = empty_o ? (push_i ? push_data_i : '0) : mem[rptr[IW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_acc && !clear_i) begin
            mem[wptr[IW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_acc) wptr <= wptr + PW'(1);
            if (pop_acc)  rptr <= rptr + PW'(1);
        end
    end

endmodule

// File: rtl/hci_ecc_err_tracker.sv
// ECC error tracker beside the TCDM initiator port: correlates flagged responses
// with request addresses, counts errors, captures the first one and flags uncorrectables.
module hci_ecc_err_tracker
    import hci_ecc_err_tracker_pkg::*;
#(
    parameter int unsigned AW              = 32,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned ADDR_FIFO_DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic                     tcdm_req_i,
    input  logic                     tcdm_gnt_i,
    input  logic [AW-1:0]            tcdm_add_i,
    input  logic                     tcdm_r_valid_i,
    input  logic                     tcdm_r_ready_i,
    input  logic                     r_data_single_err_i,
    input  logic                     r_data_multi_err_i,
    input  logic                     r_meta_single_err_i,
    input  logic                     r_meta_multi_err_i,
    output logic [CNT_W-1:0]         single_cnt_o,
    output logic [CNT_W-1:0]         multi_cnt_o,
    output logic                     first_err_valid_o,
    output logic [AW-1:0]            first_err_addr_o,
    output logic [HCI_ECC_ERR_W-1:0] first_err_type_o,
    output logic                     irq_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != CNT_MAX)) return cnt + CNT_W'(1);
        return cnt;
    endfunction

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW-1:0] pop_addr_p0;
    hci_ecc_err_t  err_p0;
    logic          vld_p0;
    logic          single_p0;
    logic          multi_p0;

    logic [CNT_W-1:0] single_cnt_p1;
    logic [CNT_W-1:0] multi_cnt_p1;
    logic             first_vld_p1;
    logic [AW-1:0]    first_addr_p1;
    hci_ecc_err_t     first_type_p1;
    logic             irq_p1;
    logic             overflow_p1;
    logic             underflow_p1;

    assign push = tcdm_req_i & tcdm_gnt_i;
    assign pop  = tcdm_r_valid_i & tcdm_r_ready_i;

    assign err_p0 = '{meta_multi:  r_meta_multi_err_i,
                      meta_single: r_meta_single_err_i,
                      data_multi:  r_data_multi_err_i,
                      data_single: r_data_single_err_i};

    // Stage p0: response handshake with its correlated address and error class
    assign vld_p0    = pop & enable_i;
    assign single_p0 = vld_p0 & ecc_is_single(err_p0);
    assign multi_p0  = vld_p0 & ecc_is_multi(err_p0);

    hci_ecc_addr_fifo #(
        .AW    (AW),
        .DEPTH (ADDR_FIFO_DEPTH)
    ) i_addr_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (push),
        .push_data_i (tcdm_add_i),
        .pop_i       (pop),
        .pop_data_o  (pop_addr_p0),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Stage p1: counters, first-error record, interrupt and sticky FIFO flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            single_cnt_p1 <= '0;
            multi_cnt_p1  <= '0;
            first_vld_p1  <= 1'b0;
            first_addr_p1 <= '0;
            first_type_p1 <= '0;
            irq_p1        <= 1'b0;
            overflow_p1   <= 1'b0;
            underflow_p1  <= 1'b0;
        end else if (clear_i) begin
            single_cnt_p1 <= '0;
            multi_cnt_p1  <= '0;
            first_vld_p1  <= 1'b0;
            first_addr_p1 <= '0;
            first_type_p1 <= '0;
            irq_p1        <= 1'b0;
            overflow_p1   <= 1'b0;
            underflow_p1  <= 1'b0;
        end else begin
            single_cnt_p1 <= sat_inc(single_cnt_p1, single_p0);
            multi_cnt_p1  <= sat_inc(multi_cnt_p1, multi_p0);
            irq_p1        <= multi_p0;
            overflow_p1   <= overflow_p1 | (push & fifo_full & ~pop);
            underflow_p1  <= underflow_p1 | (pop & fifo_empty);
            if (!first_vld_p1 && (single_p0 || multi_p0)) begin
                first_vld_p1  <= 1'b1;
                first_addr_p1 <= pop_addr_p0;
                first_type_p1 <= err_p0;
            end
        end
    end

    assign single_cnt_o      = single_cnt_p1;
    assign multi_cnt_o       = multi_cnt_p1;
    assign first_err_valid_o = first_vld_p1;
    assign first_err_addr_o  = first_addr_p1;
    assign first_err_type_o  = first_type_p1;
    assign irq_o             = irq_p1;
    assign overflow_o        = overflow_p1;
    assign underflow_o       = underflow_p1;

endmodule

// File: tb/tb_hci_ecc_err_tracker.sv
// Bench for hci_ecc_err_tracker: directed table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_hci_ecc_err_tracker;

    localparam int AW    = 32;
    localparam int CNT_W = 4;
    localparam int DEPTH = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear, en, req, gnt, rv, rr;
    logic             ds, dm, ms, mm;
    logic [AW-1:0]    add;
    logic [CNT_W-1:0] single_cnt, multi_cnt;
    logic             first_vld;
    logic [AW-1:0]    first_addr;
    logic [3:0]       first_type;
    logic             irq, ovf, unf;

    always #5 clk = ~clk;

    hci_ecc_err_tracker #(
        .AW              (AW),
        .CNT_W           (CNT_W),
        .ADDR_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .clear_i             (clear),
        .enable_i            (en),
        .tcdm_req_i          (req),
        .tcdm_gnt_i          (gnt),
        .tcdm_add_i          (add),
        .tcdm_r_valid_i      (rv),
        .tcdm_r_ready_i      (rr),
        .r_data_single_err_i (ds),
        .r_data_multi_err_i  (dm),
        .r_meta_single_err_i (ms),
        .r_meta_multi_err_i  (mm),
        .single_cnt_o        (single_cnt),
        .multi_cnt_o         (multi_cnt),
        .first_err_valid_o   (first_vld),
        .first_err_addr_o    (first_addr),
        .first_err_type_o    (first_type),
        .irq_o               (irq),
        .overflow_o          (ovf),
        .underflow_o         (unf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: outstanding addresses as a queue, plain integer counters
    logic [AW-1:0] mq[$];
    int            m_single, m_multi;
    bit            m_fv, m_irq, m_ovf, m_unf;
    logic [AW-1:0] m_faddr;
    logic [3:0]    m_ftype;

    task automatic model_reset();
        mq.delete();
        m_single = 0; m_multi = 0;
        m_fv = 0; m_irq = 0; m_ovf = 0; m_unf = 0;
        m_faddr = '0; m_ftype = '0;
    endtask

    task automatic model_step();
        bit            do_push, do_pop, s, m;
        logic [AW-1:0] pa;
        if (clear) begin
            model_reset();
            return;
        end
        do_push = req & gnt;
        do_pop  = rv & rr;
        pa      = '0;
        if (do_pop) begin
            if (mq.size() == 0) begin
                m_unf = 1;
                if (do_push) begin
                    pa      = add;
                    do_push = 0;
                end
            end else begin
                pa = mq.pop_front();
            end
        end
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(add);
            else m_ovf = 1;
        end
        s = do_pop & en & (ds | ms);
        m = do_pop & en & (dm | mm);
        if (s && m_single < CMAX) m_single++;
        if (m && m_multi < CMAX) m_multi++;
        m_irq = m;
        if (!m_fv && (s || m)) begin
            m_fv    = 1;
            m_faddr = pa;
            m_ftype = {mm, ms, dm, ds};
        end
    endtask

    task automatic cmp_model();
        chk("single_cnt", single_cnt, m_single);
        chk("multi_cnt", multi_cnt, m_multi);
        chk("first_valid", first_vld, m_fv);
        chk("first_addr", first_addr, m_faddr);
        chk("first_type", first_type, m_ftype);
        chk("irq", irq, m_irq);
        chk("overflow", ovf, m_ovf);
        chk("underflow", unf, m_unf);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_single"}, single_cnt, 0);
        chk({tag, "_multi"}, multi_cnt, 0);
        chk({tag, "_fv"}, first_vld, 0);
        chk({tag, "_faddr"}, first_addr, 0);
        chk({tag, "_ftype"}, first_type, 0);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_unf"}, unf, 0);
    endtask

    task automatic drive(input logic p, input logic [AW-1:0] a, input logic q,
                         input logic [3:0] fl, input logic e, input logic c);
        req = p; gnt = p; add = a;
        rv = q; rr = q;
        {mm, ms, dm, ds} = fl;
        en = e; clear = c;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic do_clear();
        drive(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b1);
        step();
    endtask

    typedef struct {
        logic          push;
        logic [AW-1:0] add;
        logic          pop;
        logic [3:0]    fl;
        logic [3:0]    e_single;
        logic [3:0]    e_multi;
        logic          e_fv;
        logic [AW-1:0] e_faddr;
        logic [3:0]    e_ftype;
        logic [2:0]    e_iou;
    } vec_t;

    vec_t tbl[6];
    int   nirq;
    logic [4:0] irq_hist;

    initial begin
        tbl[0] = '{1'b1, 32'h100, 1'b0, 4'h0, 4'd0, 4'd0, 1'b0, 32'h0,   4'h0, 3'b000};
        tbl[1] = '{1'b1, 32'h104, 1'b0, 4'h0, 4'd0, 4'd0, 1'b0, 32'h0,   4'h0, 3'b000};
        tbl[2] = '{1'b1, 32'h108, 1'b1, 4'h0, 4'd0, 4'd0, 1'b0, 32'h0,   4'h0, 3'b000};
        tbl[3] = '{1'b0, 32'h0,   1'b1, 4'h1, 4'd1, 4'd0, 1'b1, 32'h104, 4'h1, 3'b000};
        tbl[4] = '{1'b0, 32'h0,   1'b1, 4'h0, 4'd1, 4'd0, 1'b1, 32'h104, 4'h1, 3'b000};
        tbl[5] = '{1'b0, 32'h0,   1'b0, 4'h0, 4'd1, 4'd0, 1'b1, 32'h104, 4'h1, 3'b000};

        rst_n = 1'b0;
        drive(1'b1, 32'hdead, 1'b1, 4'hf, 1'b1, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        drive(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Three requests, responses two cycles later, single error on the second
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].push, tbl[i].add, tbl[i].pop, tbl[i].fl, 1'b1, 1'b0);
            step();
            chk($sformatf("t1_single[%0d]", i), single_cnt, tbl[i].e_single);
            chk($sformatf("t1_multi[%0d]", i), multi_cnt, tbl[i].e_multi);
            chk($sformatf("t1_fv[%0d]", i), first_vld, tbl[i].e_fv);
            chk($sformatf("t1_faddr[%0d]", i), first_addr, tbl[i].e_faddr);
            chk($sformatf("t1_ftype[%0d]", i), first_type, tbl[i].e_ftype);
            chk($sformatf("t1_iou[%0d]", i), {irq, ovf, unf}, tbl[i].e_iou);
        end

        // Multi errors on the 1st and 3rd responses
        do_clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 4'h0, 1'b1, 1'b0);
            step();
        end
        nirq = 0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b0, '0, 1'b1, 4'b0010, 1'b1, 1'b0);
                1: drive(1'b0, '0, 1'b1, 4'b0000, 1'b1, 1'b0);
                2: drive(1'b0, '0, 1'b1, 4'b1000, 1'b1, 1'b0);
                default: drive(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
            endcase
            step();
            irq_hist[i] = irq;
            if (irq === 1'b1) nirq++;
        end
        chk("t2_multi", multi_cnt, 2);
        chk("t2_irq_count", nirq, 2);
        chk("t2_irq_pattern", irq_hist, 5'b00101);
        chk("t2_faddr", first_addr, 32'h300);
        chk("t2_ftype", first_type, 4'b0010);

        // Saturation over 20 single-error responses, then clear
        do_clear();
        drive(1'b1, 32'h400, 1'b0, 4'h0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h404 + 32'(4 * i), 1'b1, 4'b0001, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b1, 4'h0, 1'b1, 1'b0);
        step();
        chk("t3_sat", single_cnt, CMAX);
        do_clear();
        chk_zero("t3_clear");

        // Fill, overflow, full push+pop, drain, then 20 pairs across the wrap
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 4'h0, 1'b1, 1'b0);
            step();
        end
        chk("t4_overflow", ovf, 1'b1);
        drive(1'b1, 32'h5f0, 1'b1, 4'h0, 1'b1, 1'b0);
        step();
        chk("t4_full_pushpop_ovf", ovf, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 4'h0, 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 4'h0, 1'b1, 1'b0);
            step();
            drive(1'b0, '0, 1'b1, (i == 12) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
            step();
        end
        chk("t4_wrap_faddr", first_addr, 32'h630);
        chk("t4_wrap_unf", unf, 1'b0);

        // Empty pops, with and without a same-cycle push
        do_clear();
        drive(1'b0, '0, 1'b1, 4'b0001, 1'b1, 1'b0);
        step();
        chk("t5_unf", unf, 1'b1);
        chk("t5_faddr0", first_addr, 32'h0);
        chk("t5_fv", first_vld, 1'b1);
        do_clear();
        drive(1'b1, 32'h200, 1'b1, 4'b0001, 1'b1, 1'b0);
        step();
        chk("t5_bypass_faddr", first_addr, 32'h200);
        chk("t5_bypass_unf", unf, 1'b1);
        drive(1'b0, '0, 1'b1, 4'h0, 1'b1, 1'b0);
        step();

        // Enable gating keeps FIFO tracking
        do_clear();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), 1'b0, 4'h0, 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b1, 4'b0001, (i == 5), 1'b0);
            step();
        end
        chk("t6_single", single_cnt, 1);
        chk("t6_faddr", first_addr, 32'h714);

        // Asynchronous reset mid-operation discards outstanding addresses
        do_clear();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h800 + 32'(4 * i), 1'b1, 4'b0001, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_zero("t7_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 4'b0001, 1'b1, 1'b0);
        step();
        chk("t7_unf", unf, 1'b1);
        chk("t7_faddr", first_addr, 32'h0);

        // Random traffic against the model
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                  {($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0)},
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 199) == 0));
            req = req & ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, total=%0d", total);
        $fatal(1);
    end

endmodule
